huffman_ac_sched: RTL and testbench

HUFFMAN_AC_SCHED -- requirements
Module: huffman_ac_sched

---
 rtl/huffman_ac_sched.sv | 173 +++++++++++++++++
 tb/tb_huffman_ac_sched.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_ac_sched.sv
// AC symbol scheduler: drives a 2-edge-latency AC encoder one scan position at a
// time and emits coefficient/ZRL/EOB symbols. Define HUFF_AC_SCHED_SYMCNT_EN to add sym_count.
module huffman_ac_sched (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_matrix,
  input  logic         blk_is_lum,
  output logic [511:0] enc_matrix,
  output logic [7:0]   enc_start_pix,
  output logic         enc_is_lum,
  input  logic [35:0]  enc_out,
  output logic         sym_valid,
  input  logic         sym_ready,
  output logic [1:0]   sym_type,
  output logic [3:0]   sym_run,
  output logic [7:0]   sym_value,
  output logic         sym_last,
  output logic         sym_is_lum
`ifdef HUFF_AC_SCHED_SYMCNT_EN
  ,
  output logic [6:0]   sym_count
`endif
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, EMIT} state_t;
  typedef enum logic [1:0] {SYM_COEF = 2'b00, SYM_ZRL = 2'b01, SYM_EOB = 2'b10} sym_type_t;

  state_t       state_q, state_d;
  logic [511:0] mat_q, mat_d;
  logic         is_lum_q, is_lum_d;
  logic [7:0]   start_q, start_d;
  logic [7:0]   next_q, next_d;
  sym_type_t    type_q, type_d;
  logic [3:0]   run_q, run_d;
  logic [7:0]   value_q, value_d;
  logic         last_q, last_d;

  logic         coef_flag;
  logic [7:0]   enc_tag;
  logic [7:0]   enc_value;
  logic [3:0]   enc_run;
  logic [7:0]   coef_next;
  logic [7:0]   zrl_next;
  logic         unused_enc_bits;

  assign coef_flag       = enc_out[20];
  assign enc_tag         = enc_out[19:12];
  assign enc_value       = enc_out[11:4];
  assign enc_run         = enc_out[3:0];
  assign unused_enc_bits = ^enc_out[35:21];

  assign coef_next = start_q + {4'd0, enc_run} + 8'd1;
  assign zrl_next  = start_q + 8'd16;

  always_comb begin
    state_d  = state_q;
    mat_d    = mat_q;
    is_lum_d = is_lum_q;
    start_d  = start_q;
    next_d   = next_q;
    type_d   = type_q;
    run_d    = run_q;
    value_d  = value_q;
    last_d   = last_q;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          mat_d    = blk_matrix;
          is_lum_d = blk_is_lum;
          start_d  = 8'd1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  state_d = CAPT;
      CAPT: begin
        state_d = EMIT;
        // A ZRL that would run past index 63 closes the block as an EOB.
        if (coef_flag) begin
          type_d  = SYM_COEF;
          run_d   = enc_run;
          value_d = enc_value;
          next_d  = coef_next;
          last_d  = (coef_next >= 8'd64);
        end else if (enc_tag == 8'h02 && start_q != 8'd2 && zrl_next < 8'd64) begin
          type_d  = SYM_ZRL;
          run_d   = '0;
          value_d = '0;
          next_d  = zrl_next;
          last_d  = 1'b0;
        end else begin
          type_d  = SYM_EOB;
          run_d   = '0;
          value_d = '0;
          next_d  = start_q;
          last_d  = 1'b1;
        end
      end
      EMIT: begin
        if (sym_ready) begin
          if (last_q) begin
            state_d = IDLE;
          end else begin
            start_d = next_q;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mat_q    <= '0;
      is_lum_q <= 1'b0;
      start_q  <= '0;
      next_q   <= '0;
      type_q   <= SYM_COEF;
      run_q    <= '0;
      value_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mat_q    <= mat_d;
      is_lum_q <= is_lum_d;
      start_q  <= start_d;
      next_q   <= next_d;
      type_q   <= type_d;
      run_q    <= run_d;
      value_q  <= value_d;
      last_q   <= last_d;
    end
  end

  assign blk_ready     = (state_q == IDLE);
  assign enc_matrix    = mat_q;
  assign enc_start_pix = start_q;
  assign enc_is_lum    = is_lum_q;
  assign sym_valid     = (state_q == EMIT);
  assign sym_type      = type_q;
  assign sym_run       = run_q;
  assign sym_value     = value_q;
  assign sym_last      = last_q;
  assign sym_is_lum    = is_lum_q;

`ifdef HUFF_AC_SCHED_SYMCNT_EN
  logic [6:0] sym_count_q, sym_count_d;

  always_comb begin
    sym_count_d = sym_count_q;
    if (state_q == IDLE && blk_valid) begin
      sym_count_d = '0;
    end else if (state_q == EMIT && sym_ready) begin
      sym_count_d = sym_count_q + 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_count_q <= '0;
    end else begin
      sym_count_q <= sym_count_d;
    end
  end

  assign sym_count = sym_count_q;
`endif

endmodule

// File: tb/tb_huffman_ac_sched.sv
// Scoreboard bench for huffman_ac_sched with a behavioural 2-edge AC encoder model.
module tb_huffman_ac_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_matrix;
  logic         blk_is_lum;
  logic [511:0] enc_matrix;
  logic [7:0]   enc_start_pix;
  logic         enc_is_lum;
  logic [35:0]  enc_out;
  logic         sym_valid;
  logic         sym_ready;
  logic [1:0]   sym_type;
  logic [3:0]   sym_run;
  logic [7:0]   sym_value;
  logic         sym_last;
  logic         sym_is_lum;
`ifdef HUFF_AC_SCHED_SYMCNT_EN
  logic [6:0]   sym_count;
`endif

  huffman_ac_sched dut (
    .clk           (clk),
    .rst           (rst),
    .blk_valid     (blk_valid),
    .blk_ready     (blk_ready),
    .blk_matrix    (blk_matrix),
    .blk_is_lum    (blk_is_lum),
    .enc_matrix    (enc_matrix),
    .enc_start_pix (enc_start_pix),
    .enc_is_lum    (enc_is_lum),
    .enc_out       (enc_out),
    .sym_valid     (sym_valid),
    .sym_ready     (sym_ready),
    .sym_type      (sym_type),
    .sym_run       (sym_run),
    .sym_value     (sym_value),
    .sym_last      (sym_last),
    .sym_is_lum    (sym_is_lum)
`ifdef HUFF_AC_SCHED_SYMCNT_EN
    ,
    .sym_count     (sym_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ;
    logic [3:0] run;
    logic [7:0] val;
    logic       last;
    logic       lum;
    logic [7:0] start;
  } sym_t;

  sym_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned hs_count = 0;
  int unsigned hold_cnt = 0;
  logic        rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Encoder model: first nonzero at or after start; 16+ zeros give ZRL. When the
  // tail is all zero and DC is odd, it pads with ZRLs instead of an EOB.
  function automatic logic [35:0] enc_fn(input logic [511:0] m, input logic [7:0] start);
    int   k;
    logic [7:0] b;
    k = -1;
    for (int i = int'(start); i < 64; i++) begin
      b = m[8*i +: 8];
      if (k < 0 && b != 8'd0) k = i;
    end
    if (k < 0) begin
      if (m[0]) return {15'h5555, 1'b0, 8'h02, 8'hAA, 4'hF};
      return {15'h5555, 1'b0, 8'h00, 8'hAA, 4'h3};
    end
    if (k - int'(start) >= 16) return {15'h5555, 1'b0, 8'h02, 8'h55, 4'hF};
    b = m[8*k +: 8];
    return {15'h5555, 1'b1, b ^ 8'h3C, b, 4'(k - int'(start))};
  endfunction

  logic [35:0] enc_s1, enc_s2;
  always @(posedge clk) begin
    enc_s1 <= enc_fn(enc_matrix, enc_start_pix);
    enc_s2 <= enc_s1;
  end
  assign enc_out = enc_s2;

  task automatic push_expected(input logic [511:0] m, input logic lum);
    int          s;
    int          ns;
    logic [35:0] e;
    sym_t        x;
    s = 1;
    forever begin
      e       = enc_fn(m, 8'(s));
      x.lum   = lum;
      x.start = 8'(s);
      x.run   = 4'd0;
      x.val   = 8'd0;
      if (e[20]) begin
        ns     = s + int'(e[3:0]) + 1;
        x.typ  = 2'b00;
        x.run  = e[3:0];
        x.val  = e[11:4];
        x.last = (ns >= 64);
      end else if (e[19:12] == 8'h02 && s != 2 && s + 16 < 64) begin
        ns     = s + 16;
        x.typ  = 2'b01;
        x.last = 1'b0;
      end else begin
        ns     = s;
        x.typ  = 2'b10;
        x.last = 1'b1;
      end
      sb_q.push_back(x);
      if (x.last) break;
      s = ns;
    end
  endtask

  // Monitor: handshakes, latency, hold stability and blk_ready behaviour.
  logic        pv = 1'b0;
  logic        pready = 1'b0;
  logic        last_hs = 1'b0;
  logic [30:0] snap;
  int unsigned evt_cyc = 0;
  int unsigned blk_sym = 0;
  sym_t        x_m;

  always @(negedge clk) begin
    if (rst) begin
      pv      = 1'b0;
      last_hs = 1'b0;
    end else begin
      if (last_hs) chk("blk_ready_return", 64'(blk_ready), 64'd1);
      last_hs = 1'b0;
      if (blk_valid && blk_ready) begin
        evt_cyc = cyc;
        blk_sym = 0;
      end
      if (sym_valid) chk("blk_ready_busy", 64'(blk_ready), 64'd0);
      if (sym_valid && !pv) chk("sym_latency", 64'(cyc - evt_cyc), 64'd4);
      if (sym_valid && pv && !pready)
        chk("sym_hold", 64'({sym_type, sym_run, sym_value, sym_last, sym_is_lum, enc_start_pix}),
            64'(snap));
      if (sym_valid && sym_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sym actual type=%0d start=%0d required=none", sym_type, enc_start_pix);
        end else begin
          x_m = sb_q.pop_front();
          chk("sym_fields", 64'({sym_type, sym_run, sym_value}), 64'({x_m.typ, x_m.run, x_m.val}));
          chk("sym_ctl", 64'({sym_last, sym_is_lum, enc_start_pix}), 64'({x_m.last, x_m.lum, x_m.start}));
`ifdef HUFF_AC_SCHED_SYMCNT_EN
          chk("sym_count_run", 64'(sym_count), 64'(blk_sym));
`endif
        end
        blk_sym++;
        hs_count++;
        evt_cyc = cyc;
        last_hs = sym_last;
      end
      pv     = sym_valid;
      pready = sym_ready;
      snap   = {sym_type, sym_run, sym_value, sym_last, sym_is_lum, enc_start_pix};
    end
  end

  initial begin
    sym_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_cnt > 0) begin
        sym_ready = 1'b0;
        hold_cnt--;
      end else begin
        sym_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  task automatic start_block(input logic [511:0] m, input logic lum);
    int unsigned w;
    push_expected(m, lum);
    @(posedge clk);
    #1;
    blk_matrix = m;
    blk_is_lum = lum;
    blk_valid  = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (blk_ready) break;
      w++;
      if (w > 4000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=blk_ready_low required=blk_ready_high");
        break;
      end
    end
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
  endtask

  task automatic wait_done();
    int unsigned w;
    w = 0;
    while (sb_q.size() != 0) begin
      @(posedge clk);
      w++;
      if (w > 4000) begin
        checks++;
        errors++;
        $display("FAIL block_timeout actual=%0d_pending required=0_pending", sb_q.size());
        sb_q.delete();
      end
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_blk_ready", 64'(blk_ready), 64'd1);
    chk("rst_sym_outputs", 64'({sym_valid, sym_type, sym_run, sym_value, sym_last, sym_is_lum}), 64'd0);
    chk("rst_enc_outputs", 64'({|enc_matrix, enc_start_pix, enc_is_lum}), 64'd0);
`ifdef HUFF_AC_SCHED_SYMCNT_EN
    chk("rst_sym_count", 64'(sym_count), 64'd0);
`endif
  endtask

  logic [511:0] m;
  int unsigned  hc0;
  int unsigned  dens;

  initial begin
    rst        = 1'b1;
    blk_valid  = 1'b0;
    blk_matrix = '0;
    blk_is_lum = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();

    // All-zero block offered as reset falls; accepted on the first edge.
    m = '0;
    push_expected(m, 1'b1);
    blk_matrix = m;
    blk_is_lum = 1'b1;
    blk_valid  = 1'b1;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    chk("accept_first_edge", 64'(blk_ready), 64'd0);
    blk_valid = 1'b0;
    wait_done();

    m = '0;
    m[15:8] = 8'h05;
    start_block(m, 1'b0);
    wait_done();

    m = '0;
    m[511:504] = 8'h01;
    start_block(m, 1'b1);
    wait_done();

    // Downstream stall across the first symbol.
    m = '0;
    m[8*7 +: 8] = 8'h33;
    m[8*30 +: 8] = 8'hC1;
    @(posedge clk);
    #1;
    hold_cnt = 10;
    start_block(m, 1'b1);
    wait_done();

    // Indices 1, 3, 5 nonzero: four symbols.
    m = '0;
    m[8*1 +: 8] = 8'h11;
    m[8*3 +: 8] = 8'h22;
    m[8*5 +: 8] = 8'h33;
    start_block(m, 1'b0);
    wait_done();
`ifdef HUFF_AC_SCHED_SYMCNT_EN
    @(negedge clk);
    chk("sym_count_total", 64'(sym_count), 64'd4);
`endif

    // Reset while the encoder is busy on the 2nd symbol.
    start_block(m, 1'b1);
    hc0 = hs_count;
    for (int i = 0; i < 100 && hs_count == hc0; i++) @(posedge clk);
    if (hs_count == hc0) begin
      checks++;
      errors++;
      $display("FAIL first_handshake_timeout actual=0 required=1");
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    sb_q.delete();
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    repeat (12) @(posedge clk);

    m = '0;
    m[15:8] = 8'h05;
    start_block(m, 1'b1);
    wait_done();

    // Randomised blocks with varying sparsity and random back-pressure.
    for (int b = 0; b < 30; b++) begin
      rand_ready = (b % 2) == 1;
      dens = $urandom_range(0, 3);
      m = '0;
      m[7:0] = 8'($urandom);
      for (int k = 1; k < 64; k++) begin
        if ((dens == 1 && $urandom_range(0, 31) == 0) ||
            (dens == 2 && $urandom_range(0, 7) == 0) ||
            (dens == 3 && $urandom_range(0, 1) == 0))
          m[8*k +: 8] = 8'($urandom_range(1, 255));
      end
      start_block(m, 1'($urandom_range(0, 1)));
      wait_done();
    end
    rand_ready = 1'b0;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
